// File: rtl/ldu_pixel_writer.sv
// Purpose     : plots line-drawer pixels as set bits in a 1-bpp framebuffer by read-modify-write.
// Latency     : pixel accepted in cycle 0 -> fb_rd_en cycle 3, fb_wr_en cycle 4, idle from cycle 5.
// Backpressure: pix_ready = registered FIFO count < FIFO_DEPTH; lost pixels set sticky overflow.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   pix_valid/x/y/ready   pixel stream from the line drawer (7-bit coordinates)
//   fb_addr/rd_en/rdata   RAM word address and read port (rdata valid the cycle after rd_en)
//   fb_wr_en/wdata        RAM write port
//   busy                  any work queued or in flight
//   overflow, clip        sticky error flags (pixel lost / pixel out of range)
//
// Datapath: pixel FIFO -> same-word coalescer (pending word) -> IDLE/RD/WR engine.
module ldu_pixel_writer #(
  parameter int FB_W       = 64,
  parameter int FB_H       = 32,
  parameter int WORD_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = $clog2(FB_W * FB_H / WORD_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_valid,
  input  logic [6:0]        pix_x,
  input  logic [6:0]        pix_y,
  output logic              pix_ready,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_rd_en,
  input  logic [WORD_W-1:0] fb_rdata,
  output logic              fb_wr_en,
  output logic [WORD_W-1:0] fb_wdata,
  output logic              busy,
  output logic              overflow,
  output logic              clip
);

  localparam int WPL = FB_W / WORD_W;   // words per framebuffer line
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int EW  = ADDR_W + WORD_W; // FIFO entry: {word addr, bit mask}

  typedef enum logic [1:0] {
    ENG_IDLE,
    ENG_RD,
    ENG_WR
  } eng_state_e;

  // ---------------- state ----------------
  logic [EW-1:0]     mem_q [FIFO_DEPTH];
  logic [EW-1:0]     mem_d [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, count_d;

  logic              pend_vld_q, pend_vld_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [WORD_W-1:0] pend_mask_q, pend_mask_d;

  eng_state_e        eng_state_q, eng_state_d;
  logic              fb_rd_en_q, fb_rd_en_d;
  logic              fb_wr_en_q, fb_wr_en_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [WORD_W-1:0] job_mask_q, job_mask_d;

  logic              overflow_q, overflow_d;
  logic              clip_q, clip_d;

  // ---------------- combinational ----------------
  logic              in_range;
  logic [ADDR_W-1:0] in_addr;
  logic [WORD_W-1:0] in_mask;
  logic              push;
  logic              pop;
  logic              handoff;
  logic              fifo_ne;
  logic [ADDR_W-1:0] head_addr;
  logic [WORD_W-1:0] head_mask;

  // Pixel -> word address and bit mask. Coordinates are widened by one bit
  // so FB_W/FB_H/WORD_W of 128 still compare correctly.
  always_comb begin
    in_range = ({1'b0, pix_x} < 8'(FB_W)) && ({1'b0, pix_y} < 8'(FB_H));
    in_addr  = ADDR_W'(int'(pix_y) * WPL + int'(pix_x) / WORD_W);
    in_mask  = WORD_W'(1) << ({1'b0, pix_x} % 8'(WORD_W));
  end

  // Ready is forced low while reset is held so every output reads 0 in reset.
  assign pix_ready = reset & (count_q < (PW + 1)'(FIFO_DEPTH));
  assign push      = pix_valid & pix_ready & in_range;
  assign fifo_ne   = (count_q != '0);
  assign head_addr = mem_q[rd_ptr_q][EW-1:WORD_W];
  assign head_mask = mem_q[rd_ptr_q][WORD_W-1:0];

  // Coalescer: merge same-word pixels into the pending word; hand the word
  // to the engine once the head moves to another word (or the FIFO drains)
  // and the engine is free.
  always_comb begin
    pop         = 1'b0;
    handoff     = 1'b0;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    pend_mask_d = pend_mask_q;
    if (!pend_vld_q) begin
      if (fifo_ne) begin
        pop         = 1'b1;
        pend_vld_d  = 1'b1;
        pend_addr_d = head_addr;
        pend_mask_d = head_mask;
      end
    end else if (fifo_ne && (head_addr == pend_addr_q)) begin
      pop         = 1'b1;
      pend_mask_d = pend_mask_q | head_mask;
    end else if (eng_state_q == ENG_IDLE) begin
      handoff = 1'b1;
      if (fifo_ne) begin
        pop         = 1'b1;
        pend_addr_d = head_addr;
        pend_mask_d = head_mask;
      end else begin
        pend_vld_d = 1'b0;
      end
    end
  end

  // FIFO pointer/count update; push and pop may coincide.
  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = {in_addr, in_mask};
    end
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + (PW + 1)'(push) - (PW + 1)'(pop);
  end

  // Engine: one read, one write, then one idle cycle per job.
  always_comb begin
    eng_state_d = eng_state_q;
    fb_rd_en_d  = 1'b0;
    fb_wr_en_d  = 1'b0;
    fb_addr_d   = fb_addr_q;
    job_mask_d  = job_mask_q;
    case (eng_state_q)
      ENG_IDLE: begin
        if (handoff) begin
          eng_state_d = ENG_RD;
          fb_rd_en_d  = 1'b1;
          fb_addr_d   = pend_addr_q;
          job_mask_d  = pend_mask_q;
        end
      end
      ENG_RD: begin
        eng_state_d = ENG_WR;
        fb_wr_en_d  = 1'b1;
      end
      ENG_WR: begin
        eng_state_d = ENG_IDLE;
      end
      default: begin
        eng_state_d = ENG_IDLE;
      end
    endcase
  end

  always_comb begin
    overflow_d = overflow_q | (pix_valid & ~pix_ready);
    clip_d     = clip_q | (pix_valid & ~in_range);
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
      pend_mask_q <= '0;
      overflow_q  <= 1'b0;
      clip_q      <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
      pend_mask_q <= pend_mask_d;
      overflow_q  <= overflow_d;
      clip_q      <= clip_d;
    end
  end

  // Engine state and its registered strobes; reset drops any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eng_state_q <= ENG_IDLE;
      fb_rd_en_q  <= 1'b0;
      fb_wr_en_q  <= 1'b0;
      fb_addr_q   <= '0;
      job_mask_q  <= '0;
    end else begin
      eng_state_q <= eng_state_d;
      fb_rd_en_q  <= fb_rd_en_d;
      fb_wr_en_q  <= fb_wr_en_d;
      fb_addr_q   <= fb_addr_d;
      job_mask_q  <= job_mask_d;
    end
  end

  // ---------------- outputs ----------------
  assign fb_rd_en = fb_rd_en_q;
  assign fb_wr_en = fb_wr_en_q;
  assign fb_addr  = fb_addr_q;
  // Read data arrives in the WR cycle itself, so the merge is combinational.
  assign fb_wdata = fb_wr_en_q ? (fb_rdata | job_mask_q) : '0;
  assign busy     = fifo_ne | pend_vld_q | (eng_state_q != ENG_IDLE);
  assign overflow = overflow_q;
  assign clip     = clip_q;

endmodule
